ldpc_dummy_decoder_pipe: RTL and testbench
==========================================

// Module: ldpc_dummy_decoder_pipe
// PURPOSE
//  Parametrised stand-in for the LDPC decoder core inside the loop wrapper.
//  - Consumes one control word per code block.
//  - Passes the block's data beats through a programmable-latency pipeline and an output FIFO.
//  - Enforces the block length; emits one status word per block once its data has drained.
//  - Lets wrapper/loop logic be verified under realistic latency, backpressure and framing errors.
// PARAMETERS
//  CTRL_WIDTH       32  control/status tdata width; must be >= LEN_WIDTH+2
//  DATA_WIDTH       64  din/dout tdata width
//  LEN_WIDTH        16  block-length field width (beats)
//  LATENCY           4  extra pipeline stages din->FIFO (0 allowed)
//  FIFO_DEPTH       16  output FIFO entries, power of 2, >= LATENCY+2
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous, active-high reset
//  s_axis_control  AxisIf.slave   CTRL_WIDTH  tdata/tvalid/tready; [LEN_WIDTH-1:0]=N beats, [LEN_WIDTH]=INV
//  s_axis_din      AxisIf.slave   DATA_WIDTH  tdata/tvalid/tready/tlast; block data
//  m_axis_status   AxisIf.master  CTRL_WIDTH  tdata/tvalid/tready; one word per block
//  m_axis_dout     AxisIf.master  DATA_WIDTH  tdata/tvalid/tready/tlast; block data out
// BEHAVIOUR
//  Reset: FSM=IDLE; all tvalid=0; control/din tready=0 during rst; status tdata=0; FIFO+pipe flushed.
//  Mid-block reset discards all in-flight data; no status is produced.
//  FSM IDLE -> DATA -> DRAIN -> STATUS -> IDLE; one block in flight.
//   IDLE:
//    - control tready=1.
//    - On handshake latch N and INV.
//    - N==0 -> STATUS, with cnt=0, err=1.
//    - Otherwise -> DATA; cnt=0.
//   DATA:
//    - din tready = (fifo_count + pipe_valid_count < FIFO_DEPTH); credit-based, never overflows.
//    - Each din handshake increments cnt.
//    - Block ends on the first of: input tlast, or cnt reaching N.
//    - err=1 if those two do not coincide (early tlast, or beat N without tlast).
//    - The ending beat is tagged last; -> DRAIN in the same cycle, and din tready=0 from the next cycle.
//    - Beats after a forced end belong to the next block; they wait for a new control word.
//   DRAIN: wait until the tagged-last beat handshakes on dout -> STATUS.
//   STATUS:
//    - m_axis_status.tvalid=1.
//    - tdata = {ctrl[CTRL_WIDTH-1:LEN_WIDTH+1] echo, err, cnt}.
//    - Held stable until tready; on handshake -> IDLE.
//    - Control tready is asserted from the following cycle.
//  Data path:
//   - dout tdata = INV ? ~din tdata : din tdata.
//   - dout tlast = tagged last; exactly one tlast per block.
//   - A din beat accepted at cycle t is visible on dout tvalid at t+LATENCY+1, if the FIFO is empty.
//   - Order preserved; no beat dropped or duplicated.
//  dout handshake:
//   - tvalid/tdata/tlast held stable while tvalid && !tready.
//   - FIFO read and write in the same cycle allowed at full/empty boundaries.
//   - Sustained throughput is 1 beat/clk when dout tready=1.
//  Widths: cnt is LEN_WIDTH bits, no wrap (cnt <= N <= 2^LEN_WIDTH-1).
//  Elaboration: $error if FIFO_DEPTH is not a power of 2 or is < LATENCY+2, or if CTRL_WIDTH < LEN_WIDTH+2.
// TESTING
//  1. Nominal: ctrl N=8, INV=0; 8 beats 0..7, tlast on beat 7; sinks always ready.
//     -> dout 0..7, tlast on 7; first beat at t+5; status = {0,err=0,cnt=8}.
//  2. Invert: N=4, INV=1, beats 0x0..0x3.
//     -> dout ~0x0..~0x3 (all-ones-based); status err=0, cnt=4.
//  3. Early tlast: N=8, tlast on beat 3.
//     -> dout 4 beats, tlast on 4th; status err=1, cnt=4.
//  4. Missing tlast: N=4, 6 beats sent, no tlast until beat 6.
//     -> dout tlast on beat 4; status err=1, cnt=4.
//     -> beats 5-6 held until the next ctrl; next block N=2 -> status err=0, cnt=2.
//  5. Backpressure: N=64, dout tready random 30%.
//     -> FIFO never overflows; data intact; din tready drops when credits are exhausted.
//  6. Reset mid-DATA after 3 beats, then N=2 block.
//     -> no stale dout/status; new block output correct; N=0 ctrl -> status err=1, cnt=0, no dout.

Source files
------------

// File: rtl/ldpc_dummy_decoder_pipe.sv
// Stand-in for the LDPC decoder core: frames one block per control word, delays the data
// through a fixed-latency pipe into an output FIFO, and reports one status word per block.
module ldpc_dummy_decoder_pipe #(
  parameter int CTRL_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_WIDTH-1:0] s_axis_control_tdata,
  input  logic                  s_axis_control_tvalid,
  output logic                  s_axis_control_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_din_tdata,
  input  logic                  s_axis_din_tvalid,
  output logic                  s_axis_din_tready,
  input  logic                  s_axis_din_tlast,
  output logic [CTRL_WIDTH-1:0] m_axis_status_tdata,
  output logic                  m_axis_status_tvalid,
  input  logic                  m_axis_status_tready,
  output logic [DATA_WIDTH-1:0] m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid,
  input  logic                  m_axis_dout_tready,
  output logic                  m_axis_dout_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  localparam int EW = CTRL_WIDTH - LEN_WIDTH - 1;

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < LATENCY + 2)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least LATENCY+2");
  end
  if (CTRL_WIDTH < LEN_WIDTH + 2) begin : g_bad_ctrl
    $error("CTRL_WIDTH must be at least LEN_WIDTH+2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DRAIN, ST_STATUS} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic                 inv_q, inv_d, err_q, err_d;
  logic [EW-1:0]        echo_q, echo_d;

  logic [CW-1:0]         fifo_count, pipe_count;
  logic                  credit_ok, ctrl_hs, din_hs, dout_hs;
  logic                  beat_hit_len, din_end;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  pipe_out_valid, pipe_out_last;
  logic [DATA_WIDTH-1:0] pipe_out_data;

  // Credits count every beat already committed to the FIFO, so the pipe never needs to stall.
  assign credit_ok             = (fifo_count + pipe_count) < CW'(FIFO_DEPTH);
  assign s_axis_control_tready = (state_q == ST_IDLE) && !rst;
  assign s_axis_din_tready     = (state_q == ST_DATA) && credit_ok && !rst;
  assign ctrl_hs               = s_axis_control_tvalid && s_axis_control_tready;
  assign din_hs                = s_axis_din_tvalid && s_axis_din_tready;
  assign dout_hs               = m_axis_dout_tvalid && m_axis_dout_tready;
  assign beat_hit_len          = (cnt_q + LEN_WIDTH'(1)) == len_q;
  assign din_end               = din_hs && (s_axis_din_tlast || beat_hit_len);
  assign in_data               = inv_q ? ~s_axis_din_tdata : s_axis_din_tdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
      echo_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      echo_q  <= echo_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    len_d                = len_q;
    cnt_d                = cnt_q;
    inv_d                = inv_q;
    err_d                = err_q;
    echo_d               = echo_q;
    m_axis_status_tvalid = 1'b0;
    m_axis_status_tdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_hs) begin
          len_d  = s_axis_control_tdata[LEN_WIDTH-1:0];
          inv_d  = s_axis_control_tdata[LEN_WIDTH];
          echo_d = s_axis_control_tdata[CTRL_WIDTH-1:LEN_WIDTH+1];
          cnt_d  = '0;
          if (s_axis_control_tdata[LEN_WIDTH-1:0] == '0) begin
            err_d   = 1'b1;
            state_d = ST_STATUS;
          end else begin
            err_d   = 1'b0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (din_hs) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (din_end) begin
            err_d   = s_axis_din_tlast != beat_hit_len;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (dout_hs && m_axis_dout_tlast) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        m_axis_status_tvalid = 1'b1;
        m_axis_status_tdata  = {echo_q, err_q, cnt_q};
        if (m_axis_status_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  if (LATENCY == 0) begin : g_nopipe
    assign pipe_out_valid = din_hs;
    assign pipe_out_data  = in_data;
    assign pipe_out_last  = din_end;
    assign pipe_count     = '0;
  end else begin : g_pipe
    logic [LATENCY-1:0]    pv;
    logic [DATA_WIDTH-1:0] pd [LATENCY];
    logic                  pl [LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
      end else begin
        pv[0] <= din_hs;
        for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= in_data;
      pl[0] <= din_end;
      for (int i = 1; i < LATENCY; i++) begin
        pd[i] <= pd[i-1];
        pl[i] <= pl[i-1];
      end
    end

    always_comb begin
      pipe_count = '0;
      for (int i = 0; i < LATENCY; i++) pipe_count = pipe_count + CW'(pv[i]);
    end

    assign pipe_out_valid = pv[LATENCY-1];
    assign pipe_out_data  = pd[LATENCY-1];
    assign pipe_out_last  = pl[LATENCY-1];
  end

  // Output FIFO: head entry drives dout directly, so it stays stable until popped.
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (pipe_out_valid) mem[wr_ptr] <= {pipe_out_last, pipe_out_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (pipe_out_valid) wr_ptr <= wr_ptr + AW'(1);
      if (dout_hs)        rd_ptr <= rd_ptr + AW'(1);
      case ({pipe_out_valid, dout_hs})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign m_axis_dout_tvalid                   = fifo_count != '0;
  assign {m_axis_dout_tlast, m_axis_dout_tdata} = mem[rd_ptr];

endmodule

// File: tb/tb_ldpc_dummy_decoder_pipe.sv
// Randomised directed bench for ldpc_dummy_decoder_pipe with a queue-based block model.
module tb_ldpc_dummy_decoder_pipe;

  localparam int CTRL_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 16;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int EW         = CTRL_WIDTH - LEN_WIDTH - 1;

  logic                  clk, rst;
  logic [CTRL_WIDTH-1:0] s_axis_control_tdata;
  logic                  s_axis_control_tvalid, s_axis_control_tready;
  logic [DATA_WIDTH-1:0] s_axis_din_tdata;
  logic                  s_axis_din_tvalid, s_axis_din_tready, s_axis_din_tlast;
  logic [CTRL_WIDTH-1:0] m_axis_status_tdata;
  logic                  m_axis_status_tvalid, m_axis_status_tready;
  logic [DATA_WIDTH-1:0] m_axis_dout_tdata;
  logic                  m_axis_dout_tvalid, m_axis_dout_tready, m_axis_dout_tlast;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [DATA_WIDTH:0]   din_q[$], model_q[$], dout_obs[$], exp_dout[$];
  logic [CTRL_WIDTH-1:0] ctrl_q[$], status_obs[$];

  int dout_ready_pct   = 100;
  int status_ready_pct = 100;
  int first_in_cyc     = -1;
  int first_out_cyc    = -1;
  int din_stall_cnt    = 0;

  ldpc_dummy_decoder_pipe #(
    .CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_control_tdata(s_axis_control_tdata), .s_axis_control_tvalid(s_axis_control_tvalid),
    .s_axis_control_tready(s_axis_control_tready),
    .s_axis_din_tdata(s_axis_din_tdata), .s_axis_din_tvalid(s_axis_din_tvalid),
    .s_axis_din_tready(s_axis_din_tready), .s_axis_din_tlast(s_axis_din_tlast),
    .m_axis_status_tdata(m_axis_status_tdata), .m_axis_status_tvalid(m_axis_status_tvalid),
    .m_axis_status_tready(m_axis_status_tready),
    .m_axis_dout_tdata(m_axis_dout_tdata), .m_axis_dout_tvalid(m_axis_dout_tvalid),
    .m_axis_dout_tready(m_axis_dout_tready), .m_axis_dout_tlast(m_axis_dout_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshakes are judged at the negedge (inputs stable until the next posedge), inputs move at posedge+1.
  initial begin
    bit hs;
    s_axis_din_tvalid = 1'b0;
    s_axis_din_tdata  = '0;
    s_axis_din_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_axis_din_tvalid && s_axis_din_tready;
      if (hs && first_in_cyc < 0) first_in_cyc = cyc;
      if (s_axis_din_tvalid && !s_axis_din_tready && m_axis_dout_tvalid && !rst) din_stall_cnt++;
      @(posedge clk);
      #1;
      if (hs && din_q.size() > 0) void'(din_q.pop_front());
      s_axis_din_tvalid = din_q.size() > 0;
      if (din_q.size() > 0) {s_axis_din_tlast, s_axis_din_tdata} = din_q[0];
    end
  end

  initial begin
    bit hs;
    s_axis_control_tvalid = 1'b0;
    s_axis_control_tdata  = '0;
    forever begin
      @(negedge clk);
      hs = s_axis_control_tvalid && s_axis_control_tready;
      @(posedge clk);
      #1;
      if (hs && ctrl_q.size() > 0) void'(ctrl_q.pop_front());
      s_axis_control_tvalid = ctrl_q.size() > 0;
      if (ctrl_q.size() > 0) s_axis_control_tdata = ctrl_q[0];
    end
  end

  initial begin
    bit                  held_valid;
    logic [DATA_WIDTH:0] held;
    held_valid           = 1'b0;
    held                 = '0;
    m_axis_dout_tready   = 1'b0;
    m_axis_status_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && m_axis_dout_tvalid) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        if (held_valid) checkOutput("dout_hold", {m_axis_dout_tlast, m_axis_dout_tdata}, held);
      end
      held_valid = m_axis_dout_tvalid && !m_axis_dout_tready && !rst;
      held       = {m_axis_dout_tlast, m_axis_dout_tdata};
      if (m_axis_dout_tvalid && m_axis_dout_tready)
        dout_obs.push_back({m_axis_dout_tlast, m_axis_dout_tdata});
      if (m_axis_status_tvalid && m_axis_status_tready) status_obs.push_back(m_axis_status_tdata);
      @(posedge clk);
      #1;
      m_axis_dout_tready   = $urandom_range(99) < dout_ready_pct;
      m_axis_status_tready = $urandom_range(99) < status_ready_pct;
    end
  end

  // Block model: consume beats until tlast or the N-th beat, whichever is first.
  task automatic modelBlock(input int n, input bit inv, input logic [EW-1:0] echo,
                            output logic [CTRL_WIDTH-1:0] st);
    int                  cnt  = 0;
    bit                  err  = 1'b1;
    bit                  done = 1'b0;
    logic [DATA_WIDTH:0] b;
    if (n != 0) begin
      while (!done && model_q.size() > 0) begin
        b    = model_q.pop_front();
        cnt++;
        done = b[DATA_WIDTH] || (cnt == n);
        err  = !(b[DATA_WIDTH] && (cnt == n));
        exp_dout.push_back({done, inv ? ~b[DATA_WIDTH-1:0] : b[DATA_WIDTH-1:0]});
      end
    end
    st = {echo, err, LEN_WIDTH'(cnt)};
  endtask

  task automatic applyStimulus(input int n, input bit inv, input int nbeats, input int tlast_idx,
                               input bit rand_data);
    logic [EW-1:0]         echo;
    logic [DATA_WIDTH-1:0] d;
    logic [CTRL_WIDTH-1:0] exp_status;
    int                    w;
    echo = EW'($urandom);
    dout_obs.delete();
    status_obs.delete();
    exp_dout.delete();
    for (int i = 0; i < nbeats; i++) begin
      d = rand_data ? {$urandom, $urandom} : DATA_WIDTH'(i);
      din_q.push_back({(i == tlast_idx), d});
      model_q.push_back({(i == tlast_idx), d});
    end
    modelBlock(n, inv, echo, exp_status);
    ctrl_q.push_back({echo, inv, LEN_WIDTH'(n)});
    w = 0;
    while (status_obs.size() == 0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    checkOutput($sformatf("n%0d_status_count", n), status_obs.size(), 1);
    if (status_obs.size() > 0) checkOutput($sformatf("n%0d_status_word", n), status_obs[0], exp_status);
    checkOutput($sformatf("n%0d_dout_count", n), dout_obs.size(), exp_dout.size());
    for (int i = 0; i < exp_dout.size(); i++)
      checkOutput($sformatf("n%0d_dout_beat%0d", n, i),
                  (i < dout_obs.size()) ? dout_obs[i] : {(DATA_WIDTH+1){1'bx}}, exp_dout[i]);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl_tready", s_axis_control_tready, 0);
    checkOutput("rst_din_tready", s_axis_din_tready, 0);
    checkOutput("rst_dout_tvalid", m_axis_dout_tvalid, 0);
    checkOutput("rst_status_tvalid", m_axis_status_tvalid, 0);
    checkOutput("rst_status_tdata", m_axis_status_tdata, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ctrl_tready", s_axis_control_tready, 1);

    $display("[TB] nominal block");
    first_in_cyc  = -1;
    first_out_cyc = -1;
    applyStimulus(8, 1'b0, 8, 7, 1'b0);
    checkOutput("first_beat_latency", first_out_cyc - first_in_cyc, LATENCY + 1);

    $display("[TB] inverted block with status backpressure");
    status_ready_pct = 40;
    applyStimulus(4, 1'b1, 4, 3, 1'b0);
    status_ready_pct = 100;

    $display("[TB] early tlast");
    applyStimulus(8, 1'b0, 4, 3, 1'b1);

    $display("[TB] missing tlast then carry-over block");
    applyStimulus(4, 1'b0, 6, 5, 1'b0);
    applyStimulus(2, 1'b0, 0, -1, 1'b0);

    $display("[TB] dout backpressure");
    dout_ready_pct = 30;
    din_stall_cnt  = 0;
    applyStimulus(64, 1'($urandom), 64, 63, 1'b1);
    checkOutput("credit_stall_seen", din_stall_cnt > 0, 1);
    dout_ready_pct = 100;

    $display("[TB] reset mid-block");
    ctrl_q.push_back({EW'($urandom), 1'b0, LEN_WIDTH'(8)});
    for (int i = 0; i < 3; i++) din_q.push_back({1'b0, DATA_WIDTH'(100 + i)});
    w = 0;
    while (din_q.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("midblock_beats_taken", din_q.size(), 0);
    rst = 1'b1;
    din_q.delete();
    ctrl_q.delete();
    repeat (2) @(negedge clk);
    checkOutput("rst2_dout_tvalid", m_axis_dout_tvalid, 0);
    checkOutput("rst2_ctrl_tready", s_axis_control_tready, 0);
    rst = 1'b0;
    dout_obs.delete();
    status_obs.delete();
    model_q.delete();
    repeat (10) @(negedge clk);
    checkOutput("post_rst_no_dout", dout_obs.size(), 0);
    checkOutput("post_rst_no_status", status_obs.size(), 0);
    checkOutput("post_rst_status_tvalid", m_axis_status_tvalid, 0);
    applyStimulus(2, 1'b0, 2, 1, 1'b1);
    applyStimulus(0, 1'b0, 0, -1, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
